mul_acc_pipe_real: RTL and testbench



---
 rtl/mul_acc_pipe_real_pkg.sv | 21 ++
 rtl/mul_acc_pipe_real_real_pipe_reg.sv | 41 ++++
 rtl/mul_acc_pipe_real.sv | 128 ++++++++++++
 tb/tb_mul_acc_pipe_real.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pipe_real_pkg.sv
// Shared types and format helpers for the pipelined fixed-point multiply-accumulate block.
package mul_acc_pipe_real_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } acc_state_e;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic int prod_exp(input int a_e, input int b_e);
        return a_e + b_e;
    endfunction

    function automatic int cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/mul_acc_pipe_real_real_pipe_reg.sv
// Fixed-point register chain with per-stage valid; all stages advance together on cke_i.
module real_pipe_reg #(
    parameter int DATA_W = 33,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cke_i,
    input  logic                     vld_i,
    input  logic signed [DATA_W-1:0] data_i,
    output logic                     vld_o,
    output logic signed [DATA_W-1:0] data_o
);

    logic [STAGES-1:0]        vld_q;
    logic signed [DATA_W-1:0] data_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (cke_i) begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cke_i) begin
            data_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[STAGES-1];
    assign data_o = data_q[STAGES-1];

endmodule

// File: rtl/mul_acc_pipe_real.sv
// Pipelined fixed-point multiplier with optional accumulation of ACC_LEN products per output.
// Valid/ready on both sides; the whole pipeline stalls while a result is held.
module mul_acc_pipe_real
    import mul_acc_pipe_real_pkg::*;
#(
    parameter int A_WIDTH     = 16,
    parameter int A_EXP       = -8,
    parameter int B_WIDTH     = 17,
    parameter int B_EXP       = -9,
    parameter int C_WIDTH     = 24,
    parameter int C_EXP       = -10,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_EN      = 1,
    parameter int ACC_LEN     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [C_WIDTH-1:0] c,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int PW    = prod_width(A_WIDTH, B_WIDTH);
    localparam int PE    = prod_exp(A_EXP, B_EXP);
    localparam int SH    = C_EXP - PE;
    localparam int RSH   = (SH > 0) ? SH : 0;
    localparam int LSH   = (SH < 0) ? -SH : 0;
    localparam int XW    = PW + LSH + C_WIDTH;
    localparam int CNT_W = cnt_width(ACC_LEN);

    // Arithmetic right shift floors toward -inf; kept wide so overflow can be detected.
    function automatic logic signed [XW-1:0] align_c(input logic signed [PW-1:0] p);
        logic signed [XW-1:0] x;
        x = XW'(p);
        return (x >>> RSH) <<< LSH;
    endfunction

    function automatic logic fits_c(input logic signed [XW-1:0] x);
        return x == XW'($signed(x[C_WIDTH-1:0]));
    endfunction

    logic                      advance;
    logic                      vld_p0;
    logic signed [PW-1:0]      prod_p0;
    logic                      vld_pn;
    logic signed [PW-1:0]      prod_pn;
    logic signed [XW-1:0]      prod_x;
    logic signed [C_WIDTH-1:0] prod_c;
    logic signed [C_WIDTH:0]   sum_d;
    logic signed [C_WIDTH-1:0] c_q;
    logic signed [C_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      out_valid_q;
    acc_state_e                state_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;
    assign vld_p0   = in_valid && advance;
    assign prod_p0  = PW'(a) * PW'(b);

    // Product stages p1..pN
    real_pipe_reg #(
        .DATA_W (PW),
        .STAGES (PIPE_STAGES)
    ) u_prod_pipe (
        .clk    (clk),
        .rst    (rst),
        .cke_i  (advance),
        .vld_i  (vld_p0),
        .data_i (prod_p0),
        .vld_o  (vld_pn),
        .data_o (prod_pn)
    );

    assign prod_x = align_c(prod_pn);
    assign prod_c = prod_x[C_WIDTH-1:0];
    assign sum_d  = {acc_q[C_WIDTH-1], acc_q} + {prod_c[C_WIDTH-1], prod_c};

    // Output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
        end else if (advance) begin
            if (ACC_EN == 0) begin
                out_valid_q <= vld_pn;
                if (vld_pn) begin
                    c_q <= prod_c;
                end
            end else begin
                if (state_q == EMIT) begin
                    out_valid_q <= 1'b0;
                    state_q     <= ACCUM;
                end
                // acc_q is already zero after an emit, so a product arriving on the handshake starts a fresh sum.
                if (vld_pn) begin
                    if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
                        c_q         <= sum_d[C_WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= EMIT;
                    end else begin
                        acc_q <= sum_d[C_WIDTH-1:0];
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && advance && vld_pn) begin
            assert (fits_c(prod_x) && (ACC_EN == 0 || sum_d[C_WIDTH] == sum_d[C_WIDTH-1]));
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_acc_pipe_real.sv
// Bench for mul_acc_pipe_real: one per-sample instance and one accumulating instance,
// checked by a scoreboard fed from a real-valued reference model.
module tb_mul_acc_pipe_real;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [15:0] a0, a1;
    logic signed [16:0] b0, b1;
    logic               v0, v1, rdy0, rdy1, ir0, ir1, ov0, ov1;
    logic signed [23:0] c0, c1;

    int total = 0;
    int bad   = 0;
    int q0[$];
    int q1[$];
    int psum  = 0;
    int pcnt  = 0;
    bit rand_on = 0;

    mul_acc_pipe_real #(
        .A_WIDTH(16), .A_EXP(-8), .B_WIDTH(17), .B_EXP(-9), .C_WIDTH(24), .C_EXP(-10),
        .PIPE_STAGES(2), .ACC_EN(0), .ACC_LEN(4)
    ) dut0 (
        .clk(clk), .rst(rst), .a(a0), .b(b0), .in_valid(v0), .in_ready(ir0),
        .c(c0), .out_valid(ov0), .out_ready(rdy0)
    );

    mul_acc_pipe_real #(
        .A_WIDTH(16), .A_EXP(-8), .B_WIDTH(17), .B_EXP(-9), .C_WIDTH(24), .C_EXP(-10),
        .PIPE_STAGES(2), .ACC_EN(1), .ACC_LEN(4)
    ) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1), .in_ready(ir1),
        .c(c1), .out_valid(ov1), .out_ready(rdy1)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Real-valued product, expressed in units of c's LSB (2^-10) and floored.
    function automatic int ref_prod(input int ar, input int br);
        real v;
        v = (real'(ar) / 256.0) * (real'(br) / 512.0);
        return $rtoi($floor(v * 1024.0));
    endfunction

    task automatic send(input int w, input int ar, input int br, output int waits);
        waits = 0;
        @(posedge clk); #1;
        if (w == 0) begin a0 = 16'(ar); b0 = 17'(br); v0 = 1'b1; end
        else        begin a1 = 16'(ar); b1 = 17'(br); v1 = 1'b1; end
        forever begin
            @(negedge clk);
            if (!rst && ((w == 0) ? ir0 : ir1)) begin
                if (w == 0) begin
                    q0.push_back(ref_prod(ar, br));
                end else begin
                    psum += ref_prod(ar, br);
                    pcnt++;
                    if (pcnt == 4) begin
                        q1.push_back(psum);
                        psum = 0;
                        pcnt = 0;
                    end
                end
                break;
            end
            waits++;
            if (waits > 200) begin
                total++; bad++;
                $display("FAIL send_timeout%0d: in_ready stayed 0 for %0d cycles, required acceptance", w, waits);
                break;
            end
        end
    endtask

    task automatic idle(input int w);
        @(posedge clk); #1;
        if (w == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        q0.delete(); q1.delete();
        psum = 0; pcnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({nm, "_q0_left"}, q0.size(), 0);
        chk({nm, "_q1_left"}, q1.size(), 0);
    endtask

    task automatic mon(input int w, input logic ov, input logic rdy, input logic ir,
                       input logic signed [23:0] c);
        int exp;
        if (rst || !ov) return;
        if (((w == 0) ? q0.size() : q1.size()) == 0) begin
            total++; bad++;
            $display("FAIL out%0d_extra: got c=%0d, expected no output", w, c);
            return;
        end
        exp = (w == 0) ? q0[0] : q1[0];
        if (rdy) begin
            chk($sformatf("out%0d_c", w), c, exp);
            if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end else begin
            chk($sformatf("hold%0d_c", w), c, exp);
            chk($sformatf("hold%0d_in_ready", w), ir, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov0, rdy0, ir0, c0);
        mon(1, ov1, rdy1, ir1, c1);
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_on) begin
                rdy0 = ($urandom_range(0, 3) != 0);
                rdy1 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        int w, wsum;
        rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; rdy0 = 1; rdy1 = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ov0", ov0, 0); chk("rst_c0", c0, 0);
        chk("rst_ov1", ov1, 0); chk("rst_c1", c1, 0);

        // Single sample, exact latency
        send(0, 384, 1024, w);
        chk("lat_accept_waits", w, 0);
        idle(0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk($sformatf("lat_ov_cycle%0d", j), ov0, (j == 3) ? 1 : 0);
        end
        drain("single");

        // Back-to-back k * 0.5
        wsum = 0;
        for (int k = 1; k <= 8; k++) begin
            send(0, k * 256, 256, w);
            wsum += w;
        end
        idle(0);
        chk("b2b_stalls", wsum, 0);
        drain("b2b");

        // Accumulate four products to 2.0
        send(1, 256, 512, w); send(1, 512, 256, w); send(1, 64, 2048, w); send(1, -256, 512, w);
        idle(1);
        drain("acc4");

        // Backpressure on the per-sample instance
        @(posedge clk); #1 rdy0 = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) send(0, (k + 1) * 100, -300 + k * 37, w);
                idle(0);
            end
            begin
                repeat (8) @(posedge clk);
                #1 rdy0 = 1'b1;
            end
        join
        drain("bp");

        // Reset in the middle of an accumulation
        send(1, 256, 512, w); send(1, 256, 512, w);
        idle(1);
        repeat (3) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("midrst_ov1", ov1, 0); chk("midrst_c1", c1, 0);
        for (int k = 0; k < 4; k++) send(1, 256, 512, w);
        idle(1);
        chk("midrst_expect", q1.size() == 1 ? q1[0] : -1, 4096);
        drain("midrst");

        // Quantisation: 2^-17 floors to 0, -2^-17 floors to -2^-10
        send(0, 1, 1, w); send(0, -1, 1, w);
        idle(0);
        drain("quant");

        // Randomised traffic with random backpressure on both instances
        rand_on = 1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(0, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 8191)) - 4096, w);
                    if ($urandom_range(0, 3) == 0) idle(0);
                end
                idle(0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    send(1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 8191)) - 4096, w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                idle(1);
            end
        join
        rand_on = 0;
        @(posedge clk); #2;
        rdy0 = 1'b1; rdy1 = 1'b1;
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
